reg_bus_master: RTL

- Initiator for the team's simple register bus (wr_en/rd_en/addr/wdata/rdata), used to drive regset-style slaves.
- Accepts one command at a time from an upstream controller (test sequencer or CPU bridge) over a valid/ready handshake.
- Issues the bus access, captures read data, and can optionally read back a write to verify it.
- Returns one response per command over a valid/ready handshake.

---
 rtl/reg_bus_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/reg_bus_master.sv
// Register-bus initiator: takes one command per valid/ready handshake, runs the bus
// access (optionally read-back verified) and returns exactly one response per command.
module reg_bus_master #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_verify,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  txn_count
);

  localparam int WAIT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RESP
  } state_e;

  state_e              state_q,     state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,   rsp_err_d;
  logic                wr_en_q,     wr_en_d;
  logic                rd_en_q,     rd_en_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [CNT_W-1:0]    txn_q,       txn_d;
  logic                verify_q,    verify_d;
  logic [WAIT_W-1:0]   wait_q,      wait_d;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned; that is what keeps this block free of latches.
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wr_en_d     = wr_en_q;
    rd_en_d     = rd_en_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    txn_d       = txn_q;
    verify_d    = verify_q;
    wait_d      = wait_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          verify_d    = cmd_write && cmd_verify;
          cmd_ready_d = 1'b0;
          wait_d      = '0;
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer straight away without touching the bus.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (cmd_write) begin
            state_d = S_WR;
            wr_en_d = 1'b1;
          end else begin
            state_d = S_RD;
            rd_en_d = 1'b1;
          end
        end
      end

      S_WR: begin
        wr_en_d = 1'b0;
        if (verify_q) begin
          state_d = S_RD;
          rd_en_d = 1'b1;
          wait_d  = '0;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end

      S_RD: begin
        if (wait_q == WAIT_LAST) begin
          // Last rd_en cycle: the edge that ends it captures the slave's data.
          rd_en_d     = 1'b0;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
          rsp_err_d   = verify_q && (rdata != wdata_q);
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          txn_d       = txn_q + 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      txn_q       <= '0;
      verify_q    <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      txn_q       <= txn_d;
      verify_q    <= verify_d;
      wait_q      <= wait_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign txn_count = txn_q;

endmodule
